// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Double-register the line into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits,
// break detection and a valid/ready output holding one word.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx_line,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LP_HALF      = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LP_FULL      = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LP_LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]    LP_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          LP_PAR_ODD   = (PARITY_MODE == PARITY_ODD);

    logic                  w_rxs;
    uart_state_t           r_state;
    logic [CW-1:0]         r_cnt;
    logic [3:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_perr;
    logic                  r_ferr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_frame_err;
    logic                  r_parity_err;
    logic                  r_overrun;
    logic                  r_busy;

    uart_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (uart_rx_line),
        .o_sync  (w_rxs)
    );

    // Receive FSM, bit timer and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            // A delivery later in this block overrides this clear, so a word
            // accepted on the completion cycle is replaced without overrun.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= ST_START;
                        r_cnt   <= LP_HALF;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_rxs) begin
                        r_state <= ST_DATA;
                        r_cnt   <= LP_FULL;
                        r_idx   <= '0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift <= {w_rxs, r_shift[DATA_WIDTH-1:1]};
                        r_cnt   <= LP_FULL;
                        if (r_idx == LP_LAST_DATA) begin
                            r_idx   <= '0;
                            r_state <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_perr  <= ((^r_shift) ^ w_rxs) != LP_PAR_ODD;
                        r_cnt   <= LP_FULL;
                        r_state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_idx == LP_LAST_STOP) begin
                        if (r_out_valid && !out_ready) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_out_data   <= r_shift;
                            r_out_valid  <= 1'b1;
                            r_frame_err  <= r_ferr | ~w_rxs;
                            r_parity_err <= r_perr;
                        end
                        if (!w_rxs) begin
                            r_state <= ST_BREAK;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_ferr <= r_ferr | ~w_rxs;
                        r_idx  <= r_idx + 1'b1;
                        r_cnt  <= LP_FULL;
                    end
                end

                ST_BREAK: begin
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance.
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_n = 1'b1;
    logic       line_p = 1'b1;
    logic       ready = 1'b1;

    logic [7:0] data_n, data_p;
    logic       valid_n, valid_p;
    logic       ferr_n, ferr_p;
    logic       perr_n, perr_p;
    logic       ovr_n, ovr_p;
    logic       busy_n, busy_p;

    int n_vec  = 0;
    int n_miss = 0;

    // handshake monitors
    int         hs_n = 0, hs_p = 0, ovr_cnt_n = 0, ovr_cnt_p = 0;
    logic [7:0] last_data_n = '0, last_data_p = '0;
    logic       last_ferr_n = 1'b0, last_ferr_p = 1'b0;
    logic       last_perr_n = 1'b0, last_perr_p = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (CPB),
        .PARITY_MODE  (0),
        .STOP_BITS    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_line (line_n),
        .out_data     (data_n),
        .out_valid    (valid_n),
        .out_ready    (ready),
        .frame_err    (ferr_n),
        .parity_err   (perr_n),
        .overrun      (ovr_n),
        .busy         (busy_n)
    );

    uart_rx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (CPB),
        .PARITY_MODE  (1),
        .STOP_BITS    (1)
    ) dut_p (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_line (line_p),
        .out_data     (data_p),
        .out_valid    (valid_p),
        .out_ready    (ready),
        .frame_err    (ferr_p),
        .parity_err   (perr_p),
        .overrun      (ovr_p),
        .busy         (busy_p)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_n && ready) begin
                hs_n        <= hs_n + 1;
                last_data_n <= data_n;
                last_ferr_n <= ferr_n;
                last_perr_n <= perr_n;
            end
            if (valid_p && ready) begin
                hs_p        <= hs_p + 1;
                last_data_p <= data_p;
                last_ferr_p <= ferr_p;
                last_perr_p <= perr_p;
            end
            if (ovr_n) ovr_cnt_n <= ovr_cnt_n + 1;
            if (ovr_p) ovr_cnt_p <= ovr_cnt_p + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_bit(input bit sel, input logic b);
        if (sel) line_p = b;
        else     line_n = b;
        tick(CPB);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input logic par, input logic stop);
        logic [7:0] v;
        v = d;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, v[i]);
        if (par_en) drive_bit(sel, par);
        drive_bit(sel, stop);
    endtask

    int base;

    initial begin
        // reset state
        rst = 1'b1;
        tick(3);
        check("rst_valid", {31'd0, valid_n}, 32'd0);
        check("rst_data",  {24'd0, data_n},  32'd0);
        check("rst_ferr",  {31'd0, ferr_n},  32'd0);
        check("rst_perr",  {31'd0, perr_n},  32'd0);
        check("rst_ovr",   {31'd0, ovr_n},   32'd0);
        check("rst_busy",  {31'd0, busy_n},  32'd0);
        check("rst_p_out", {24'd0, data_p, valid_p, ferr_p, perr_p, ovr_p, busy_p, 3'd0}, 32'd0);
        rst = 1'b0;
        tick(6);

        // 0x50, 8N1
        base = hs_n;
        send_frame(1'b0, 8'h50, 1'b0, 1'b0, 1'b1);
        tick(8);
        check("p50_count", hs_n - base, 32'd1);
        check("p50_data",  {24'd0, last_data_n}, 32'h50);
        check("p50_ferr",  {31'd0, last_ferr_n}, 32'd0);
        check("p50_perr",  {31'd0, last_perr_n}, 32'd0);
        check("p50_busy",  {31'd0, busy_n},      32'd0);

        // 0xA5 even parity, wrong parity bit (correct would be 0)
        base = hs_p;
        send_frame(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        tick(8);
        check("a5_count", hs_p - base, 32'd1);
        check("a5_data",  {24'd0, last_data_p}, 32'hA5);
        check("a5_perr",  {31'd0, last_perr_p}, 32'd1);
        check("a5_ferr",  {31'd0, last_ferr_p}, 32'd0);
        check("a5_ovr",   ovr_cnt_p,            32'd0);

        // 0x3C with low stop bit, then line held low
        base = hs_n;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick(40);
        check("brk_count", hs_n - base, 32'd1);
        check("brk_data",  {24'd0, last_data_n}, 32'h3C);
        check("brk_ferr",  {31'd0, last_ferr_n}, 32'd1);
        check("brk_perr",  {31'd0, last_perr_n}, 32'd0);
        check("brk_busy_low", {31'd0, busy_n}, 32'd1);
        line_n = 1'b1;
        tick(1);
        check("brk_busy_edge", {31'd0, busy_n}, 32'd1);
        tick(5);
        check("brk_busy_idle", {31'd0, busy_n}, 32'd0);
        tick(4);

        // back-to-back 0x11, 0x22 with ready low
        base = hs_n;
        check("ovr_pre_valid", {31'd0, valid_n}, 32'd0);
        ready = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        tick(8);
        check("ovr_valid", {31'd0, valid_n}, 32'd1);
        check("ovr_data",  {24'd0, data_n},  32'h11);
        check("ovr_pulses", ovr_cnt_n, 32'd1);
        ready = 1'b1;
        tick(12);
        check("ovr_count", hs_n - base, 32'd1);
        check("ovr_hs_data", {24'd0, last_data_n}, 32'h11);
        check("ovr_valid_drop", {31'd0, valid_n}, 32'd0);

        // single-cycle glitch
        base = hs_n;
        line_n = 1'b0;
        tick(1);
        line_n = 1'b1;
        tick(2);
        check("gl_busy_start", {31'd0, busy_n}, 32'd1);
        tick(3);
        check("gl_busy_back", {31'd0, busy_n}, 32'd0);
        tick(30);
        check("gl_no_valid", hs_n - base, 32'd0);

        // reset mid-DATA of 0x7E, then 0x81
        base = hs_n;
        line_n = 1'b0;
        tick(CPB);
        line_n = 1'b0;
        tick(CPB);
        line_n = 1'b1;
        tick(CPB);
        check("mr_busy_pre", {31'd0, busy_n}, 32'd1);
        rst = 1'b1;
        tick(2);
        check("mr_rst_outs", {24'd0, data_n, valid_n, ferr_n, perr_n, ovr_n, busy_n, 3'd0}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(20);
        check("mr_no_partial", hs_n - base, 32'd0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        tick(10);
        check("mr_count", hs_n - base, 32'd1);
        check("mr_data",  {24'd0, last_data_n}, 32'h81);
        check("mr_ferr",  {31'd0, last_ferr_n}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
